// File: rtl/mem_if_pkg.sv
// Shared definitions for the single-port shared-bus memory and its bus master.
// Holds the FSM state encoding, default geometry and a depth helper.
package mem_if_pkg;

    // Default word width and address width of the memory
    localparam int DATA_SIZE_DEFAULT = 8;
    localparam int ADDRESS_DEFAULT   = 4;

    // Number of words addressed by a given address width
    function automatic int unsigned mem_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int MEM_DEPTH_DEFAULT = 32'd1 << ADDRESS_DEFAULT;

    // Master FSM states; ST_TURN is reachable only in the turnaround build
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_LATCH = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_TURN     = 3'd4
    } mem_state_e;

endpackage

// File: rtl/memory_inout_master.sv
// memory_inout_master: bus initiator for a single-port memory with a shared
// bidirectional data bus. Accepts one word request at a time on a
// valid/ready port, sequences cs / write_en / read_en / address, drives the
// bus only while writing and returns read data on a one-cycle response pulse.
//
// Optional build macro: MEM_MASTER_TURNAROUND_EN
//   When defined, a dead TURN cycle (cs and enables low, bus released)
//   follows every read so the memory has let go of the bus before the
//   master can drive it again. Read latency is unchanged; the next accept
//   is one cycle later.
module memory_inout_master
    import mem_if_pkg::*;
#(
    parameter int data_size = DATA_SIZE_DEFAULT,
    parameter int address   = ADDRESS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [address-1:0]   req_addr,
    input  logic [data_size-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [data_size-1:0] rsp_rdata,
    output logic                 mem_cs,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic [address-1:0]   mem_address,
    inout  wire  [data_size-1:0] mem_data_io
);

    mem_state_e             state_q, state_d;
    logic [address-1:0]     addr_q, addr_d;
    logic [data_size-1:0]   wdata_q, wdata_d;
    logic                   cs_q, cs_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   ready_q, ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [data_size-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   accept_s;

    // A request is taken only while the registered ready is high (IDLE)
    assign accept_s = req_valid && ready_q;

    // Next-state logic, request latching and read-data capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RD_LATCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RD_LATCH: begin
                state_d = ST_RD_DRIVE;
            end
            ST_RD_DRIVE: begin
                // The memory is driving the bus this cycle; sample it at the edge
                rsp_rdata_d = mem_data_io;
                rsp_valid_d = 1'b1;
`ifdef MEM_MASTER_TURNAROUND_EN
                state_d = ST_TURN;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef MEM_MASTER_TURNAROUND_EN
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory controls and ready decoded from the next state so they are flops
    always_comb begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_WRITE: begin
                cs_d = 1'b1;
                we_d = 1'b1;
            end
            ST_RD_LATCH: begin
                cs_d = 1'b1;
            end
            ST_RD_DRIVE: begin
                cs_d = 1'b1;
                re_d = 1'b1;
            end
            default: begin
                // TURN and any illegal encoding: everything released
                cs_d    = 1'b0;
                we_d    = 1'b0;
                re_d    = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the controls asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= {address{1'b0}};
            wdata_q     <= {data_size{1'b0}};
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {data_size{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            re_q        <= re_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The only master drive onto the shared bus, gated by the registered write enable
    assign mem_data_io = we_q ? wdata_q : {data_size{1'bz}};

    assign req_ready    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_cs       = cs_q;
    assign mem_write_en = we_q;
    assign mem_read_en  = re_q;
    assign mem_address  = addr_q;

endmodule

// File: tb/tb_memory_inout_master.sv
// Directed testbench for memory_inout_master with a behavioural shared-bus
// memory. Expected values are hand-computed from the stimulus.
// Build with MEM_MASTER_TURNAROUND_EN defined to exercise the TURN build.
module tb_memory_inout_master;

`ifdef MEM_MASTER_TURNAROUND_EN
    localparam int RD_TURN = 1;
`else
    localparam int RD_TURN = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_cs;
    logic       mem_write_en;
    logic       mem_read_en;
    logic [3:0] mem_address;
    wire  [7:0] mem_data_io;

    int n_checks;
    int n_fail;

    memory_inout_master #(.data_size(8), .address(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_cs       (mem_cs),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_address  (mem_address),
        .mem_data_io  (mem_data_io)
    );

    // Behavioural memory: commits writes, loads its output latch in the
    // cs-only cycle and drives the bus while read_en is high without write_en
    logic [7:0] mem_arr [16];
    logic [7:0] mem_out;

    always @(posedge clk) begin
        if (mem_cs && mem_write_en) begin
            mem_arr[mem_address] <= mem_data_io;
        end else if (mem_cs && !mem_read_en) begin
            mem_out <= mem_arr[mem_address];
        end
    end

    assign mem_data_io = (mem_cs && mem_read_en && !mem_write_en) ? mem_out : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Write with request fields scrambled as soon as the request is taken
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~d;
        check_eq("wr_we", {31'd0, mem_write_en}, 32'd1);
        check_eq("wr_addr", {28'd0, mem_address}, {28'd0, a});
        check_eq("wr_bus", {24'd0, mem_data_io}, {24'd0, d});
        tick();
    endtask

    // Read and check the response arrives in the third cycle after accept
    task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        req_write = 1'b0;
        req_addr  = a;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
        req_addr  = ~a;
        check_eq({tag, "_c1_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_latch_addr"}, {28'd0, mem_address}, {28'd0, a});
        tick();
        check_eq({tag, "_c2_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_drive_re"}, {31'd0, mem_read_en}, 32'd1);
        check_eq({tag, "_drive_addr"}, {28'd0, mem_address}, {28'd0, a});
        tick();
        check_eq({tag, "_c3_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp});
        check_eq({tag, "_c3_ready"}, {31'd0, req_ready}, (RD_TURN == 0) ? 32'd1 : 32'd0);
        tick();
        check_eq({tag, "_c4_valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // Stream tables for the back-to-back valid test
    logic       op_w [8];
    logic [3:0] op_a [8];
    logic [7:0] op_d [8];

    task automatic set_op(input int i);
        req_write = op_w[i];
        req_addr  = op_a[i];
        req_wdata = op_d[i];
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int idx;
        int acc_k;
        logic will_acc;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_eq("rst_cs", {31'd0, mem_cs}, 32'd0);
        check_eq("rst_we", {31'd0, mem_write_en}, 32'd0);
        check_eq("rst_re", {31'd0, mem_read_en}, 32'd0);
        check_eq("rst_addr", {28'd0, mem_address}, 32'd0);

        // Reset asserted while in RD_DRIVE aborts the read
        req_write = 1'b0;
        req_addr  = 4'd2;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("abort_in_drive", {31'd0, mem_read_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_cs", {31'd0, mem_cs}, 32'd0);
        check_eq("abort_re", {31'd0, mem_read_en}, 32'd0);
        check_eq("abort_we", {31'd0, mem_write_en}, 32'd0);
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check_eq("abort_no_rsp1", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("abort_no_rsp2", {31'd0, rsp_valid}, 32'd0);
        check_eq("abort_cs_after", {31'd0, mem_cs}, 32'd0);

        // Write then read back one word
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 8'hA5, "rd3");

        // Fill every address with addr*0x11, read back from the top
        for (int a = 0; a < 16; a++) begin
            do_write(a[3:0], 8'(a * 17));
        end
        do_read(4'd15, 8'hFF, "rd15");
        for (int a = 14; a >= 0; a--) begin
            do_read(a[3:0], 8'(a * 17), "fill");
        end

        // Valid held high, alternating writes and reads to addresses 10..13
        for (int i = 0; i < 4; i++) begin
            op_w[2*i]   = 1'b1;
            op_a[2*i]   = 4'(10 + i);
            op_d[2*i]   = 8'(8'hC0 + i);
            op_w[2*i+1] = 1'b0;
            op_a[2*i+1] = 4'(10 + i);
            op_d[2*i+1] = 8'(8'hC0 + i);
        end
        idx = 0;
        set_op(0);
        req_valid = 1'b1;
        wait_ready();
        for (int cyc = 0; cyc < 80 && (idx < 8 || exp_q.size() > 0); cyc++) begin
            if (mem_write_en && mem_read_en) begin
                check_eq("excl_both_en", 32'd1, 32'd0);
            end
            if (mem_cs && req_ready) begin
                check_eq("ready_while_busy", 32'd1, 32'd0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_extra_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    check_eq("stream_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
                end
            end
            will_acc = req_valid && req_ready;
            if (will_acc) begin
                if (!op_w[idx]) exp_q.push_back(op_d[idx]);
                idx++;
            end
            tick();
            if (will_acc) begin
                if (idx < 8) begin
                    set_op(idx);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check_eq("stream_accepts", idx, 32'd8);
        check_eq("stream_rsp_left", exp_q.size(), 32'd0);

        // Read immediately followed by a write held valid
        req_write = 1'b0;
        req_addr  = 4'd7;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_write = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 8'h7E;
        acc_k = 0;
        for (int k = 1; k <= 6 && acc_k == 0; k++) begin
            tick();
            if (k == 2) begin
                check_eq("rw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                check_eq("rw_rdata", {24'd0, rsp_rdata}, 32'h77);
                check_eq("rw_cs_gap", {31'd0, mem_cs}, 32'd0);
                check_eq("rw_we_gap", {31'd0, mem_write_en}, 32'd0);
            end
            if (mem_write_en) acc_k = k;
        end
        req_valid = 1'b0;
        check_eq("rw_accept_edge", acc_k, 32'(3 + RD_TURN));
        tick();
        do_read(4'd7, 8'h7E, "rw_back");

        // Request fields changed while busy are ignored
        req_write = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 8'h5A;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_addr  = 4'd9;
        req_wdata = 8'hEE;
        check_eq("busy_addr", {28'd0, mem_address}, 32'd5);
        check_eq("busy_bus", {24'd0, mem_data_io}, 32'h5A);
        req_valid = 1'b0;
        tick();
        do_read(4'd5, 8'h5A, "busy_rd5");
        do_read(4'd9, 8'h99, "busy_rd9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
